// File: rtl/key_conditioner.sv
// Multi-key pushbutton conditioner: per-key 2-flop synchroniser, debounce FSM,
// registered clean level, and 1-cycle press / release / auto-repeat strobes.
module key_conditioner #(
   parameter int NUM_KEYS    = 4,
   parameter int CLK_FREQ    = 50000000,
   parameter int DEBOUNCE_MS = 10,
   parameter int HOLD_MS     = 500,
   parameter int REPEAT_MS   = 100
) (
   input  logic                CLOCK_50,
   input  logic                reset,
   input  logic [NUM_KEYS-1:0] KEY,
   output logic [NUM_KEYS-1:0] key_clean,
   output logic [NUM_KEYS-1:0] key_press,
   output logic [NUM_KEYS-1:0] key_release,
   output logic [NUM_KEYS-1:0] key_repeat
);

   localparam int DB_RAW   = CLK_FREQ / 1000 * DEBOUNCE_MS;
   localparam int HOLD_RAW = CLK_FREQ / 1000 * HOLD_MS;
   localparam int REP_RAW  = CLK_FREQ / 1000 * REPEAT_MS;
   localparam int DB_CYC   = (DB_RAW   < 1) ? 1 : DB_RAW;
   localparam int HOLD_CYC = (HOLD_RAW < 1) ? 1 : HOLD_RAW;
   localparam int REP_CYC  = (REP_RAW  < 1) ? 1 : REP_RAW;
   localparam int TM_MAX   = (HOLD_CYC > REP_CYC) ? HOLD_CYC : REP_CYC;
   localparam int DB_W     = $clog2(DB_CYC + 1);
   localparam int TM_W     = $clog2(TM_MAX + 1);

   localparam logic [DB_W-1:0] DB_LAST   = DB_W'(DB_CYC - 1);
   localparam logic [TM_W-1:0] HOLD_LAST = TM_W'(HOLD_CYC - 1);
   localparam logic [TM_W-1:0] REP_LAST  = TM_W'(REP_CYC - 1);
   localparam logic [TM_W-1:0] TM_SAT    = TM_W'(TM_MAX);

   typedef enum logic [1:0] {
      ST_RELEASED,
      ST_PRESS_PEND,
      ST_PRESSED,
      ST_RELEASE_PEND
   } state_t;

   logic [NUM_KEYS-1:0] r_sync1;
   logic [NUM_KEYS-1:0] r_sync2;
   state_t              r_state     [NUM_KEYS];
   logic [DB_W-1:0]     r_db_cnt    [NUM_KEYS];
   logic [TM_W-1:0]     r_tm_cnt    [NUM_KEYS];
   logic [NUM_KEYS-1:0] r_rep_phase;

   // NOTE: every per-key array entry is cleared by reset, so a held key re-debounces cleanly.
   always_ff @(posedge CLOCK_50 or posedge reset) begin
      if (reset) begin
         r_sync1     <= '1;
         r_sync2     <= '1;
         r_rep_phase <= '0;
         key_clean   <= '1;
         key_press   <= '0;
         key_release <= '0;
         key_repeat  <= '0;
         for (int k = 0; k < NUM_KEYS; k++) begin
            r_state[k]  <= ST_RELEASED;
            r_db_cnt[k] <= '0;
            r_tm_cnt[k] <= '0;
         end
      end else begin
         // NOTE: non-blocking throughout, so r_sync2 here is last cycle's value, giving two real flop stages.
         r_sync1     <= KEY;
         r_sync2     <= r_sync1;
         key_press   <= '0;
         key_release <= '0;
         key_repeat  <= '0;
         for (int k = 0; k < NUM_KEYS; k++) begin
            case (r_state[k])
               ST_RELEASED: begin
                  if (!r_sync2[k]) begin
                     r_state[k]  <= ST_PRESS_PEND;
                     r_db_cnt[k] <= DB_W'(1);
                  end
               end
               ST_PRESS_PEND: begin
                  if (r_sync2[k]) begin
                     r_state[k]  <= ST_RELEASED;
                     r_db_cnt[k] <= '0;
                  end else if (r_db_cnt[k] >= DB_LAST) begin
                     r_state[k]     <= ST_PRESSED;
                     r_db_cnt[k]    <= '0;
                     r_tm_cnt[k]    <= '0;
                     r_rep_phase[k] <= 1'b0;
                     key_clean[k]   <= 1'b0;
                     key_press[k]   <= 1'b1;
                     key_repeat[k]  <= 1'b1;
                  end else begin
                     r_db_cnt[k] <= r_db_cnt[k] + 1'b1;
                  end
               end
               ST_PRESSED: begin
                  if (r_sync2[k]) begin
                     r_state[k]  <= ST_RELEASE_PEND;
                     r_db_cnt[k] <= DB_W'(1);
                  end else if (r_tm_cnt[k] >= (r_rep_phase[k] ? REP_LAST : HOLD_LAST)) begin
                     // First expiry ends the hold delay; later ones pace the repeat rate.
                     r_tm_cnt[k]    <= '0;
                     r_rep_phase[k] <= 1'b1;
                     key_repeat[k]  <= 1'b1;
                  end else if (r_tm_cnt[k] != TM_SAT) begin
                     r_tm_cnt[k] <= r_tm_cnt[k] + 1'b1;
                  end
               end
               ST_RELEASE_PEND: begin
                  if (!r_sync2[k]) begin
                     r_state[k]  <= ST_PRESSED;
                     r_db_cnt[k] <= '0;
                  end else if (r_db_cnt[k] >= DB_LAST) begin
                     r_state[k]     <= ST_RELEASED;
                     r_db_cnt[k]    <= '0;
                     key_clean[k]   <= 1'b1;
                     key_release[k] <= 1'b1;
                  end else begin
                     r_db_cnt[k] <= r_db_cnt[k] + 1'b1;
                  end
               end
               default: begin
                  r_state[k]  <= ST_RELEASED;
                  r_db_cnt[k] <= '0;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_key_conditioner.sv
// Self-checking bench for key_conditioner: expected strobes are queued with their
// cycle numbers as keys are driven, then popped as the DUT emits strobes.
module tb_key_conditioner;

   localparam int NK = 4;
   localparam int KD_PRESS = 0;
   localparam int KD_REL   = 1;
   localparam int KD_REP   = 2;

   typedef struct {
      int cyc;
      int key;
      int kind;
   } ev_t;

   logic          clk;
   logic          reset;
   logic [NK-1:0] KEY;
   logic [NK-1:0] key_clean;
   logic [NK-1:0] key_press;
   logic [NK-1:0] key_release;
   logic [NK-1:0] key_repeat;

   int  cyc;
   int  n_tests;
   int  n_fail;
   ev_t exp_q[$];

   key_conditioner #(
      .NUM_KEYS   (NK),
      .CLK_FREQ   (1000),
      .DEBOUNCE_MS(4),
      .HOLD_MS    (10),
      .REPEAT_MS  (3)
   ) dut (
      .CLOCK_50   (clk),
      .reset      (reset),
      .KEY        (KEY),
      .key_clean  (key_clean),
      .key_press  (key_press),
      .key_release(key_release),
      .key_repeat (key_repeat)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   function automatic string kind_name(input int kd);
      case (kd)
         KD_PRESS: return "press";
         KD_REL:   return "release";
         default:  return "repeat";
      endcase
   endfunction

   function automatic void expect_ev(input int c, input int k, input int kd);
      ev_t e;
      e.cyc  = c;
      e.key  = k;
      e.kind = kd;
      exp_q.push_back(e);
   endfunction

   // Advance one cycle, sample on the falling edge, and score every strobe seen.
   task automatic step();
      ev_t  e;
      logic s;
      @(negedge clk);
      while (exp_q.size() > 0 && exp_q[0].cyc < cyc) begin
         e = exp_q.pop_front();
         n_tests++;
         n_fail++;
         $display("FAIL missed_%s key%0d: never seen, required at cycle %0d",
                  kind_name(e.kind), e.key, e.cyc);
      end
      for (int k = 0; k < NK; k++) begin
         for (int kd = 0; kd < 3; kd++) begin
            s = (kd == KD_PRESS) ? key_press[k] : (kd == KD_REL) ? key_release[k] : key_repeat[k];
            if (s !== 1'b0) begin
               n_tests++;
               if (exp_q.size() == 0) begin
                  n_fail++;
                  $display("FAIL unexpected_%s key%0d: seen at cycle %0d, none required",
                           kind_name(kd), k, cyc);
               end else begin
                  e = exp_q.pop_front();
                  if (e.cyc != cyc || e.key != k || e.kind != kd) begin
                     n_fail++;
                     $display("FAIL strobe_order: seen %s key%0d at cycle %0d, required %s key%0d at cycle %0d",
                              kind_name(kd), k, cyc, kind_name(e.kind), e.key, e.cyc);
                  end
               end
            end
         end
      end
   endtask

   task automatic wait_until(input int c);
      while (cyc < c) step();
   endtask

   task automatic test_reset();
      int seen;
      KEY   = '1;
      reset = 1'b0;
      #2 reset = 1'b1;
      repeat (3) step();
      n_tests++;
      if (key_clean !== 4'hF) begin
         n_fail++;
         $display("FAIL reset_clean: got %h, required %h", key_clean, 4'hF);
      end
      n_tests++;
      if ({key_press, key_release, key_repeat} !== 12'h000) begin
         n_fail++;
         $display("FAIL reset_strobes: got %h, required 000", {key_press, key_release, key_repeat});
      end
      reset = 1'b0;
      seen  = 0;
      repeat (50) begin
         step();
         if (key_clean !== 4'hF || |{key_press, key_release, key_repeat}) seen++;
      end
      n_tests++;
      if (seen !== 0) begin
         n_fail++;
         $display("FAIL idle_quiet: %0d active cycles, required 0", seen);
      end
   endtask

   task automatic test_single_press();
      int t0;
      t0 = cyc;
      KEY[0] = 1'b0;
      expect_ev(t0 + 6, 0, KD_PRESS);
      expect_ev(t0 + 6, 0, KD_REP);
      wait_until(t0 + 5);
      n_tests++;
      if (key_clean[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL press_early_clean: got %b at edge+5, required 1", key_clean[0]);
      end
      wait_until(t0 + 6);
      n_tests++;
      if (key_clean[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL press_clean: got %b at edge+6, required 0", key_clean[0]);
      end
      wait_until(t0 + 8);
      KEY[0] = 1'b1;
      expect_ev(t0 + 14, 0, KD_REL);
      wait_until(t0 + 13);
      n_tests++;
      if (key_clean[0] !== 1'b0) begin
         n_fail++;
         $display("FAIL release_early_clean: got %b, required 0", key_clean[0]);
      end
      wait_until(t0 + 14);
      n_tests++;
      if (key_clean[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL release_clean: got %b, required 1", key_clean[0]);
      end
      wait_until(t0 + 30);
   endtask

   task automatic test_bounce();
      int last;
      KEY[1] = 1'b0; step();
      KEY[1] = 1'b1; step();
      KEY[1] = 1'b0; step();
      KEY[1] = 1'b1; step();
      KEY[1] = 1'b0;
      last = cyc;
      expect_ev(last + 6, 1, KD_PRESS);
      expect_ev(last + 6, 1, KD_REP);
      wait_until(last + 5);
      n_tests++;
      if (key_clean[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL bounce_early_clean: got %b, required 1", key_clean[1]);
      end
      wait_until(last + 6);
      n_tests++;
      if (key_clean[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL bounce_clean: got %b, required 0", key_clean[1]);
      end
      wait_until(last + 8);
      KEY[1] = 1'b1;
      expect_ev(last + 14, 1, KD_REL);
      wait_until(last + 25);
   endtask

   task automatic test_hold_repeat();
      int p;
      KEY[2] = 1'b0;
      p = cyc + 6;
      expect_ev(p, 2, KD_PRESS);
      expect_ev(p, 2, KD_REP);
      for (int j = 0; j < 7; j++) expect_ev(p + 10 + 3 * j, 2, KD_REP);
      wait_until(p + 28);
      KEY[2] = 1'b1;
      expect_ev(p + 34, 2, KD_REL);
      wait_until(p + 33);
      n_tests++;
      if (key_clean[2] !== 1'b0) begin
         n_fail++;
         $display("FAIL hold_clean: got %b, required 0", key_clean[2]);
      end
      wait_until(p + 34);
      n_tests++;
      if (key_clean[2] !== 1'b1) begin
         n_fail++;
         $display("FAIL hold_release_clean: got %b, required 1", key_clean[2]);
      end
      wait_until(p + 50);
   endtask

   task automatic test_simultaneous();
      int p;
      KEY[0] = 1'b0;
      KEY[3] = 1'b0;
      p = cyc + 6;
      expect_ev(p, 0, KD_PRESS);
      expect_ev(p, 0, KD_REP);
      expect_ev(p, 3, KD_PRESS);
      expect_ev(p, 3, KD_REP);
      wait_until(p + 2);
      KEY[3] = 1'b1;
      expect_ev(p + 8, 3, KD_REL);
      expect_ev(p + 10, 0, KD_REP);
      wait_until(p + 4);
      n_tests++;
      if (key_clean !== 4'b0110) begin
         n_fail++;
         $display("FAIL both_clean: got %b, required 0110", key_clean);
      end
      wait_until(p + 8);
      n_tests++;
      if (key_clean !== 4'b1110) begin
         n_fail++;
         $display("FAIL independent_clean: got %b, required 1110", key_clean);
      end
      wait_until(p + 10);
      KEY[0] = 1'b1;
      expect_ev(p + 16, 0, KD_REL);
      wait_until(p + 30);
      n_tests++;
      if (key_clean !== 4'hF) begin
         n_fail++;
         $display("FAIL both_released_clean: got %b, required 1111", key_clean);
      end
   endtask

   task automatic test_reset_mid_press();
      int t0;
      int t1;
      t0 = cyc;
      KEY[1] = 1'b0;
      expect_ev(t0 + 6, 1, KD_PRESS);
      expect_ev(t0 + 6, 1, KD_REP);
      wait_until(t0 + 9);
      reset = 1'b1;
      #1;
      n_tests++;
      if (key_clean !== 4'hF) begin
         n_fail++;
         $display("FAIL midreset_clean: got %h, required F", key_clean);
      end
      n_tests++;
      if ({key_press, key_release, key_repeat} !== 12'h000) begin
         n_fail++;
         $display("FAIL midreset_strobes: got %h, required 000", {key_press, key_release, key_repeat});
      end
      repeat (3) step();
      reset = 1'b0;
      t1 = cyc;
      expect_ev(t1 + 6, 1, KD_PRESS);
      expect_ev(t1 + 6, 1, KD_REP);
      wait_until(t1 + 5);
      n_tests++;
      if (key_clean[1] !== 1'b1) begin
         n_fail++;
         $display("FAIL repress_early_clean: got %b, required 1", key_clean[1]);
      end
      wait_until(t1 + 6);
      n_tests++;
      if (key_clean[1] !== 1'b0) begin
         n_fail++;
         $display("FAIL repress_clean: got %b, required 0", key_clean[1]);
      end
      wait_until(t1 + 8);
      KEY[1] = 1'b1;
      expect_ev(t1 + 14, 1, KD_REL);
      wait_until(t1 + 25);
   endtask

   initial begin
      n_tests = 0;
      n_fail  = 0;
      test_reset();
      test_single_press();
      test_bounce();
      test_hold_repeat();
      test_simultaneous();
      test_reset_mid_press();
      repeat (10) step();
      n_tests++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: %0d expected strobes left, required 0", exp_q.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
